behavioral: RTL and testbench



---
 rtl/behavioral_pkg.sv | 19 +
 rtl/behavioral_sensor_vote.sv | 33 +++
 rtl/structural.sv | 84 ++++++++
 rtl/behavioral.sv | 55 +++++
 tb/tb_behavioral.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/behavioral_pkg.sv
// rtl/behavioral_pkg.sv - shared constants and types for the sensor-vote blocks
//
// Purpose: single home for the sensor width, count width and the default
// THRESHOLD / REGISTERED settings, used by both behavioral and structural.
// Ports: none (package).
package behavioral_pkg;

    localparam int SENSOR_W           = 4;
    localparam int CNT_W              = 3;
    localparam int THRESHOLD_DEFAULT  = 3;
    localparam bit REGISTERED_DEFAULT = 1'b1;

    // One vote result: detection flag plus the population count behind it.
    typedef struct packed {
        logic             f;
        logic [CNT_W-1:0] cnt;
    } vote_t;

endpackage

// File: rtl/behavioral_sensor_vote.sv
// rtl/behavioral_sensor_vote.sv - combinational popcount and threshold vote
//
// Purpose: counts asserted sensor bits and flags when the count reaches
// THRESHOLD. Pure combinational; registering is left to the parent.
// Ports:
//   Xin  in  [SENSOR_W-1:0]  sensor vector
//   cnt  out [CNT_W-1:0]     number of asserted bits, 0..4
//   f    out                 1 when cnt >= THRESHOLD
module sensor_vote
    import behavioral_pkg::*;
#(
    parameter int THRESHOLD = THRESHOLD_DEFAULT
) (
    input  logic [SENSOR_W-1:0] Xin,
    output logic [CNT_W-1:0]    cnt,
    output logic                f
);

    // Each bit is widened before summing so the total of four never wraps.
    always_comb begin
        cnt = CNT_W'(Xin[0]) + CNT_W'(Xin[1]) + CNT_W'(Xin[2]) + CNT_W'(Xin[3]);
    end

    // THRESHOLD 0 is special-cased so no always-true comparison is built.
    generate
        if (THRESHOLD <= 0) begin : g_always
            assign f = 1'b1;
        end else begin : g_compare
            assign f = (cnt >= CNT_W'(THRESHOLD));
        end
    endgenerate

endmodule

// File: rtl/structural.sv
// rtl/structural.sv - gate-level sibling of behavioral, same ports and timing
//
// Purpose: the same vote built from gate primitives: a two-level adder for
// the count and a sum-of-products for the threshold flag.
// Ports:
//   Xin       in  [3:0]  sensor vector
//   Fout      out        detection result
//   clk       in         system clock, rising edge
//   rst_n     in         asynchronous active-low reset
//   ones_cnt  out [2:0]  population count of Xin
module structural
    import behavioral_pkg::*;
#(
    parameter int THRESHOLD  = THRESHOLD_DEFAULT,
    parameter bit REGISTERED = REGISTERED_DEFAULT
) (
    input  logic [SENSOR_W-1:0] Xin,
    output logic                Fout,
    input  logic                clk,
    input  logic                rst_n,
    output logic [CNT_W-1:0]    ones_cnt
);

    wire s01, c01, s23, c23, c_low;
    wire cnt0, cnt1, cnt2;
    wire f_c;

    // Pair sums, then combine. c_low can only be set when each pair holds
    // exactly one bit, so c01/c23 are then 0 and bit 2 reduces to c01&c23.
    xor g_s01 (s01, Xin[0], Xin[1]);
    and g_c01 (c01, Xin[0], Xin[1]);
    xor g_s23 (s23, Xin[2], Xin[3]);
    and g_c23 (c23, Xin[2], Xin[3]);
    xor g_b0  (cnt0, s01, s23);
    and g_cl  (c_low, s01, s23);
    xor g_b1  (cnt1, c01, c23, c_low);
    and g_b2  (cnt2, c01, c23);

    generate
        if (THRESHOLD <= 0) begin : g_t0
            assign f_c = 1'b1;
        end else if (THRESHOLD == 1) begin : g_t1
            or g_f (f_c, Xin[0], Xin[1], Xin[2], Xin[3]);
        end else if (THRESHOLD == 2) begin : g_t2
            wire p01, p02, p03, p12, p13, p23;
            and g_p01 (p01, Xin[0], Xin[1]);
            and g_p02 (p02, Xin[0], Xin[2]);
            and g_p03 (p03, Xin[0], Xin[3]);
            and g_p12 (p12, Xin[1], Xin[2]);
            and g_p13 (p13, Xin[1], Xin[3]);
            and g_p23 (p23, Xin[2], Xin[3]);
            or  g_f   (f_c, p01, p02, p03, p12, p13, p23);
        end else if (THRESHOLD == 3) begin : g_t3
            wire t012, t013, t023, t123;
            and g_t012 (t012, Xin[0], Xin[1], Xin[2]);
            and g_t013 (t013, Xin[0], Xin[1], Xin[3]);
            and g_t023 (t023, Xin[0], Xin[2], Xin[3]);
            and g_t123 (t123, Xin[1], Xin[2], Xin[3]);
            or  g_f    (f_c, t012, t013, t023, t123);
        end else begin : g_t4
            and g_f (f_c, Xin[0], Xin[1], Xin[2], Xin[3]);
        end
    endgenerate

    generate
        if (REGISTERED) begin : g_reg
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    Fout     <= 1'b0;
                    ones_cnt <= '0;
                end else begin
                    Fout     <= f_c;
                    ones_cnt <= {cnt2, cnt1, cnt0};
                end
            end
        end else begin : g_comb
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst_n;
            assign Fout     = f_c;
            assign ones_cnt = {cnt2, cnt1, cnt0};
        end
    endgenerate

endmodule

// File: rtl/behavioral.sv
// rtl/behavioral.sv - sensor vote with optional output register (behavioral core)
//
// Purpose: reports whether at least THRESHOLD of four sensors are asserted,
// together with the raw count. REGISTERED=1 gives one cycle of latency with
// asynchronous clear; REGISTERED=0 is a pure combinational path.
// Ports:
//   Xin       in  [3:0]  sensor vector
//   Fout      out        detection result
//   clk       in         system clock, rising edge
//   rst_n     in         asynchronous active-low reset
//   ones_cnt  out [2:0]  population count of Xin
module behavioral
    import behavioral_pkg::*;
#(
    parameter int THRESHOLD  = THRESHOLD_DEFAULT,
    parameter bit REGISTERED = REGISTERED_DEFAULT
) (
    input  logic [SENSOR_W-1:0] Xin,
    output logic                Fout,
    input  logic                clk,
    input  logic                rst_n,
    output logic [CNT_W-1:0]    ones_cnt
);

    vote_t vote;

    sensor_vote #(
        .THRESHOLD (THRESHOLD)
    ) u_vote (
        .Xin (Xin),
        .cnt (vote.cnt),
        .f   (vote.f)
    );

    generate
        if (REGISTERED) begin : g_reg
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    Fout     <= 1'b0;
                    ones_cnt <= '0;
                end else begin
                    Fout     <= vote.f;
                    ones_cnt <= vote.cnt;
                end
            end
        end else begin : g_comb
            // Clock and reset have no function on the combinational build.
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst_n;
            assign Fout     = vote.f;
            assign ones_cnt = vote.cnt;
        end
    endgenerate

endmodule

// File: tb/tb_behavioral.sv
// tb/tb_behavioral.sv - self-checking bench for behavioral and structural
module tb_behavioral;

    logic       clk;
    logic       rst_n;
    logic [3:0] Xin;

    logic       f3, f1, f4, fc, fs;
    logic [2:0] c3, c1, c4, cc, cs;

    int checks;
    int errors;

    typedef struct {
        logic [3:0] x;
        logic       f3;
        logic       f1;
        logic       f4;
        logic [2:0] cnt;
    } exp_t;

    exp_t sb[$];

    behavioral dut (
        .Xin(Xin), .Fout(f3), .clk(clk), .rst_n(rst_n), .ones_cnt(c3)
    );
    behavioral #(.THRESHOLD(1)) dut_t1 (
        .Xin(Xin), .Fout(f1), .clk(clk), .rst_n(rst_n), .ones_cnt(c1)
    );
    behavioral #(.THRESHOLD(4)) dut_t4 (
        .Xin(Xin), .Fout(f4), .clk(clk), .rst_n(rst_n), .ones_cnt(c4)
    );
    behavioral #(.REGISTERED(1'b0)) dut_comb (
        .Xin(Xin), .Fout(fc), .clk(clk), .rst_n(rst_n), .ones_cnt(cc)
    );
    structural ref_struct (
        .Xin(Xin), .Fout(fs), .clk(clk), .rst_n(rst_n), .ones_cnt(cs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(input logic [3:0] v);
        exp_t e;
        int   n;
        n = 0;
        for (int i = 0; i < 4; i++) if (v[i]) n++;
        e.x   = v;
        e.cnt = 3'(n);
        e.f3  = (v inside {4'd7, 4'd11, 4'd13, 4'd14, 4'd15});
        e.f1  = (v != 4'd0);
        e.f4  = (v == 4'd15);
        return e;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        Xin   = 4'd15;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            checks++;
            if ({f3, c3} !== 4'b0) begin
                errors++;
                $display("FAIL reset_dut: Fout=%b cnt=%0d, required 0/0", f3, c3);
            end
            checks++;
            if ({f1, c1, f4, c4} !== 8'b0) begin
                errors++;
                $display("FAIL reset_thr: t1=%b/%0d t4=%b/%0d, required 0/0", f1, c1, f4, c4);
            end
            checks++;
            if ({fs, cs} !== 4'b0) begin
                errors++;
                $display("FAIL reset_struct: Fout=%b cnt=%0d, required 0/0", fs, cs);
            end
        end
    endtask

    task automatic test_sweep();
        exp_t       e;
        logic       prev_f;
        logic [2:0] prev_c;
        prev_f = 1'b0;
        prev_c = 3'd0;
        // Release reset and present 0 on the same falling edge; the next
        // rising edge must sample it normally.
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            rst_n = 1'b1;
            Xin   = 4'(i % 16);
            sb.push_back(model(Xin));
            @(posedge clk);
            #1;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sweep_sb: scoreboard empty at step %0d, required 1 entry", i);
            end else begin
                e = sb.pop_front();
                checks++;
                if (f3 !== e.f3 || c3 !== e.cnt) begin
                    errors++;
                    $display("FAIL sweep_t3 x=%0d: Fout=%b cnt=%0d, required %b/%0d", e.x, f3, c3, e.f3, e.cnt);
                end
                checks++;
                if (f1 !== e.f1 || f4 !== e.f4) begin
                    errors++;
                    $display("FAIL sweep_t1t4 x=%0d: t1=%b t4=%b, required %b %b", e.x, f1, f4, e.f1, e.f4);
                end
                checks++;
                if (fs !== e.f3 || cs !== e.cnt) begin
                    errors++;
                    $display("FAIL sweep_struct x=%0d: Fout=%b cnt=%0d, required %b/%0d", e.x, fs, cs, e.f3, e.cnt);
                end
                if (i == 16) begin
                    checks++;
                    if (prev_f !== 1'b1 || prev_c !== 3'd4 || f3 !== 1'b0 || c3 !== 3'd0) begin
                        errors++;
                        $display("FAIL wrap: Fout %b->%b cnt %0d->%0d, required 1->0 and 4->0", prev_f, f3, prev_c, c3);
                    end
                end
            end
            prev_f = f3;
            prev_c = c3;
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            Xin = 4'($urandom_range(0, 15));
            sb.push_back(model(Xin));
            @(posedge clk);
            #1;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL b2b_sb: scoreboard empty at step %0d, required 1 entry", i);
            end else begin
                e = sb.pop_front();
                if (f3 !== e.f3 || c3 !== e.cnt || fs !== e.f3 || f1 !== e.f1 || f4 !== e.f4) begin
                    errors++;
                    $display("FAIL b2b x=%0d: t3=%b/%0d s=%b t1=%b t4=%b, required %b/%0d %b %b %b",
                             e.x, f3, c3, fs, f1, f4, e.f3, e.cnt, e.f3, e.f1, e.f4);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        exp_t e;
        @(negedge clk);
        Xin = 4'd15;
        @(posedge clk);
        #1;
        checks++;
        if (f3 !== 1'b1) begin
            errors++;
            $display("FAIL async_pre: Fout=%b, required 1", f3);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (f3 !== 1'b0 || c3 !== 3'd0 || fs !== 1'b0 || cs !== 3'd0) begin
            errors++;
            $display("FAIL async_clear: dut=%b/%0d struct=%b/%0d, required 0/0", f3, c3, fs, cs);
        end
        @(negedge clk);
        rst_n = 1'b1;
        Xin   = 4'd13;
        sb.push_back(model(Xin));
        @(posedge clk);
        #1;
        checks++;
        e = sb.pop_front();
        if (f3 !== e.f3 || c3 !== e.cnt) begin
            errors++;
            $display("FAIL release: Fout=%b cnt=%0d, required %b/%0d", f3, c3, e.f3, e.cnt);
        end
    endtask

    task automatic test_comb();
        exp_t e;
        for (int v = 0; v < 16; v++) begin
            @(negedge clk);
            Xin = 4'(v);
            e   = model(Xin);
            #1;
            checks++;
            if (fc !== e.f3 || cc !== e.cnt) begin
                errors++;
                $display("FAIL comb x=%0d: Fout=%b cnt=%0d, required %b/%0d", v, fc, cc, e.f3, e.cnt);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        Xin    = 4'd0;
        rst_n  = 1'b0;
        test_reset();
        test_sweep();
        test_back_to_back();
        test_async_reset();
        test_comb();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
